fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 101 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests words from program memory, presents them to
// the control unit with a valid/ready handshake and computes the next pc.
module fetch_unit #(
    parameter int word_size   = 32,
    parameter int opcode_size = 5,
    parameter int pc_width    = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [pc_width-1:0]  imem_addr,
    input  logic [word_size-1:0] imem_rdata,
    input  logic                 imem_valid,
    input  logic [3:0]           flags,
    output logic [word_size-1:0] instr_out,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [pc_width-1:0]  pc_out,
    output logic                 halted,
    output logic [15:0]          retired_cnt
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;

    localparam logic [opcode_size-1:0] OP_J   = opcode_size'(5'b10110);
    localparam logic [opcode_size-1:0] OP_BEQ = opcode_size'(5'b10111);
    localparam logic [opcode_size-1:0] OP_HLT = opcode_size'(5'b11000);

    logic [1:0]             state;
    logic [pc_width-1:0]    pc;
    logic [word_size-1:0]   instr_reg;
    logic [opcode_size-1:0] opcode;
    logic [pc_width-1:0]    target;
    logic [pc_width-1:0]    pc_next_seq;
    logic                   unused_flags;

    assign opcode       = instr_reg[word_size-1 -: opcode_size];
    assign target       = instr_reg[pc_width-1:0];
    assign pc_next_seq  = pc_out + pc_width'(1);
    assign unused_flags = &{1'b0, flags[3], flags[1:0]};

    // Outputs decode straight from state so an async reset takes effect at once.
    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == ISSUE);
    assign instr_out   = instr_valid ? instr_reg : '0;
    assign halted      = (state == HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= '0;
            pc_out      <= '0;
            instr_reg   <= '0;
            retired_cnt <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_valid) begin
                        instr_reg <= imem_rdata;
                        pc_out    <= pc;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        if (retired_cnt != 16'hFFFF)
                            retired_cnt <= retired_cnt + 16'd1;
                        // BEQ samples Z at the transfer edge itself.
                        case (opcode)
                            OP_J: begin
                                pc    <= target;
                                state <= FETCH;
                            end
                            OP_BEQ: begin
                                pc    <= flags[2] ? target : pc_next_seq;
                                state <= FETCH;
                            end
                            OP_HLT: begin
                                state <= HALT;
                            end
                            default: begin
                                pc    <= pc_next_seq;
                                state <= FETCH;
                            end
                        endcase
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule
